// File: rtl/fpu_operand_dispatch.sv
// FPU operand dispatcher: routes operand pairs by class code into
// per-channel FIFOs, discarding and counting out-of-range selections.
module fpu_operand_dispatch #(
  parameter  int WIDTH = 37,
  parameter  int NCH   = 3,
  parameter  int DEPTH = 2,
  localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      in_sel,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*WIDTH-1:0] out_a,
  output logic [NCH*WIDTH-1:0] out_b,
  output logic                 sel_err,
  output logic [7:0]           drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [SELW:0] NCH_L = SELW'(NCH - 1) + 1'b1;

  logic [WIDTH-1:0] mem_a_q [NCH][DEPTH];
  logic [WIDTH-1:0] mem_b_q [NCH][DEPTH];
  logic [WIDTH-1:0] hold_a_q [NCH];
  logic [WIDTH-1:0] hold_b_q [NCH];
  logic [AW-1:0]    rd_q [NCH];
  logic [AW-1:0]    wr_q [NCH];
  logic [CW-1:0]    cnt_q [NCH];
  logic             sel_err_q;
  logic [7:0]       drop_q;

  logic [NCH-1:0] full;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic           sel_ok;
  logic           sel_full;
  logic           acc;

  always_comb begin
    sel_ok   = {1'b0, in_sel} < NCH_L;
    sel_full = 1'b0;
    out_a    = '0;
    out_b    = '0;
    for (int c = 0; c < NCH; c++) begin
      full[c]      = cnt_q[c] == CW'(DEPTH);
      out_valid[c] = cnt_q[c] != '0;
      pop[c]       = out_valid[c] && out_ready[c];
      if (in_sel == SELW'(c)) sel_full = full[c];
      out_a[c*WIDTH +: WIDTH] = out_valid[c] ?
        mem_a_q[c][rd_q[c]] : hold_a_q[c];
      out_b[c*WIDTH +: WIDTH] = out_valid[c] ?
        mem_b_q[c][rd_q[c]] : hold_b_q[c];
    end
    in_ready = rst_n && (!sel_ok || !sel_full);
    acc      = in_valid && in_ready;
    for (int c = 0; c < NCH; c++)
      push[c] = acc && sel_ok && (in_sel == SELW'(c));
  end

  assign sel_err  = sel_err_q;
  assign drop_cnt = drop_q;

  // Payload storage needs no reset; only pointers decide what is visible
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) begin
        mem_a_q[c][wr_q[c]] <= in_a;
        mem_b_q[c][wr_q[c]] <= in_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        rd_q[c]     <= '0;
        wr_q[c]     <= '0;
        cnt_q[c]    <= '0;
        hold_a_q[c] <= '0;
        hold_b_q[c] <= '0;
      end
      sel_err_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (push[c]) wr_q[c] <= wr_q[c] + AW'(1);
        if (pop[c]) begin
          rd_q[c]     <= rd_q[c] + AW'(1);
          hold_a_q[c] <= mem_a_q[c][rd_q[c]];
          hold_b_q[c] <= mem_b_q[c][rd_q[c]];
        end
        if (push[c] && !pop[c])
          cnt_q[c] <= cnt_q[c] + CW'(1);
        else if (pop[c] && !push[c])
          cnt_q[c] <= cnt_q[c] - CW'(1);
      end
      if (acc && !sel_ok) begin
        sel_err_q <= 1'b1;
        if (drop_q != 8'hff) drop_q <= drop_q + 8'd1;
      end
    end
  end

endmodule

// File: doc/fpu_operand_dispatch.md
FPU_OPERAND_DISPATCH -- requirements
Module: fpu_operand_dispatch

Interface
REQ-001 Parameter WIDTH, default 37: bit width of each operand.
REQ-002 Parameter NCH, default 3: number of output channels (0 subnormal, 1 normal, 2 mixed); legal range 2..8.
REQ-003 Parameter DEPTH, default 2: entries per channel queue; power of two, at least 2.
REQ-004 Derived SELW = max(1, clog2(NCH)).
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1: synchronous, active-low reset.
REQ-007 Port in_valid, input, 1: an operand pair is offered.
REQ-008 Port in_ready, output, 1: dispatcher accepts the offered pair this cycle.
REQ-009 Port in_sel, input, SELW: destination channel, the class code.
REQ-010 Port in_a, input, WIDTH: operand A.
REQ-011 Port in_b, input, WIDTH: operand B.
REQ-012 Port out_valid, output, NCH: bit c means channel c is presenting a pair.
REQ-013 Port out_ready, input, NCH: bit c means the channel-c consumer takes the pair.
REQ-014 Port out_a, output, NCH*WIDTH: channel c's operand A in bits [c*WIDTH +: WIDTH].
REQ-015 Port out_b, output, NCH*WIDTH: channel c's operand B, same slicing as out_a.
REQ-016 Port sel_err, output, 1: sticky flag; an out-of-range in_sel was accepted.
REQ-017 Port drop_cnt, output, 8: saturating count of discarded pairs.

Function
REQ-018 Transfer rules: an input transfer occurs when in_valid && in_ready; a channel-c output transfer occurs when out_valid[c] && out_ready[c].
REQ-019 in_ready is combinational: it is 1 when in_sel >= NCH, and otherwise equals !full[in_sel]; it does not depend on in_valid.
REQ-020 Each channel has an independent FIFO of DEPTH entries, with first-in first-out order preserved within a channel; there is no ordering relation between channels.
REQ-021 An accepted pair with in_sel < NCH is written to the tail of queue in_sel at the clock edge.
REQ-022 Latency: a pair accepted at edge k is presented no earlier than the cycle after edge k, so out_valid rises after edge k; there is no combinational input-to-output bypass.
REQ-023 out_valid[c] is 1 exactly when queue c holds at least one entry.
REQ-024 out_a/out_b slice c shows the head entry of queue c while out_valid[c] is 1.
REQ-025 When queue c is empty, slice c holds the last value it presented, or 0 if nothing has been presented since reset; this is the legacy hold behaviour with no latches.
REQ-026 A full channel rejects new pushes even when it pops in the same cycle; no simultaneous push-through on a full queue.
REQ-027 On a non-full channel, a push and a pop in the same cycle leave the occupancy unchanged and keep order correct.
REQ-028 Read and write pointers wrap modulo DEPTH.
REQ-029 Occupancy never exceeds DEPTH and never goes below 0; out_ready asserted on an empty channel has no effect.
REQ-030 Pairs accepted with in_sel >= NCH are discarded: no queue changes, sel_err is set, and drop_cnt increments.
REQ-031 drop_cnt saturates at 255.
REQ-032 sel_err stays set until reset.
REQ-033 Inputs are ignored when in_valid is 0; in_sel, in_a and in_b may change freely in that case.

Reset
REQ-034 While rst_n is 0 at a clock edge, all pointers and occupancies clear to 0, out_valid becomes 0, out_a and out_b become 0, sel_err becomes 0 and drop_cnt becomes 0.
REQ-035 in_ready is forced to 0 while rst_n is 0.
REQ-036 A reset asserted mid-operation discards all queued pairs; a transfer offered during the reset cycle is not accepted.
REQ-037 The first push is accepted at the first edge with rst_n = 1.

Verification
REQ-038 Basic routing, defaults: push (sel 0, A=1, B=2), (sel 1, A=3, B=4), (sel 2, A=5, B=6) with all out_ready = 0 -> each out_valid bit is 1 one cycle after its push, and each slice shows its pair.
REQ-039 Full and order, defaults: three pushes to channel 1 with out_ready[1] = 0 -> in_ready = 0 on the third offer. Then raise out_ready[1] for 2 cycles -> pairs drain in push order, out_valid[1] = 0 afterwards, and slice 1 holds the second pair.
REQ-040 Simultaneous push and pop: with channel 0 holding 1 entry, push to channel 0 while out_ready[0] = 1 -> occupancy stays 1 and the new pair is at the head next cycle. Repeat with channel 0 full -> push rejected, pop succeeds.
REQ-041 Invalid selection: push with in_sel = 3 at NCH = 3, 300 times -> in_ready = 1, no out_valid change, sel_err = 1, drop_cnt = 255.
REQ-042 Reset mid-operation: fill all channels, then drive rst_n = 0 for 1 cycle -> all outputs are 0 and in_ready = 0 in that cycle; the next push is presented normally.
REQ-043 Parameter sweep: random traffic against a scoreboard at (WIDTH 37, NCH 3, DEPTH 2), (WIDTH 64, NCH 8, DEPTH 4) and (WIDTH 16, NCH 2, DEPTH 8) -> no loss, duplication or reordering within any channel.
